// File: rtl/expr_ctrl_pkg.sv
// Shared encodings for the expression-solver controller: ALU opcodes, FSM states and
// register indices used on the ALU operand selects.
package expr_ctrl_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_MUL  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    localparam logic [1:0] R0 = 2'd0;
    localparam logic [1:0] R1 = 2'd1;
    localparam logic [1:0] R2 = 2'd2;
    localparam logic [1:0] R3 = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_ADD  = 3'd2,
        S_MUL  = 3'd3,
        S_SUB  = 3'd4,
        S_DONE = 3'd5
    } state_e;

endpackage

// File: rtl/expr_ctrl.sv
// Control FSM for the expression-solver datapath: gathers R0..R3 over valid/ready, then
// drives the shared ALU through ((R0 + R1) * R2) - R3 accumulating into R0.
module expr_ctrl
    import expr_ctrl_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 1,
    parameter int unsigned CNT_W      = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_in_valid,
    output logic       o_in_ready,
    output logic [3:0] o_ld,
    output logic       o_sel_in,
    output logic [1:0] o_alu_a_sel,
    output logic [1:0] o_alu_b_sel,
    output logic [1:0] o_alu_op,
    output logic       o_out_ld,
    output logic       o_busy,
    output logic       o_done
);

    localparam logic [CNT_W-1:0] MC_LAST = CNT_W'(MUL_CYCLES - 1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [1:0]       r_cnt;
    logic [1:0]       w_cnt_nxt;
    logic [CNT_W-1:0] r_mc;
    logic [CNT_W-1:0] w_mc_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 2'd0;
            r_mc    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mc    <= w_mc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mc_nxt    = r_mc;
        o_in_ready  = 1'b0;
        o_ld        = 4'b0000;
        o_sel_in    = 1'b0;
        o_alu_a_sel = R0;
        o_alu_b_sel = R0;
        o_alu_op    = OP_PASS;
        o_out_ld    = 1'b0;
        o_busy      = 1'b1;
        o_done      = 1'b0;

        case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    w_state_nxt = S_LOAD;
                    w_cnt_nxt   = 2'd0;
                end
            end
            S_LOAD: begin
                o_in_ready = 1'b1;
                if (i_in_valid) begin
                    o_ld      = 4'b0001 << r_cnt;
                    w_cnt_nxt = r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        w_state_nxt = S_ADD;
                    end
                end
            end
            S_ADD: begin
                o_alu_b_sel = R1;
                o_alu_op    = OP_ADD;
                o_sel_in    = 1'b1;
                o_ld        = 4'b0001;
                w_state_nxt = S_MUL;
                w_mc_nxt    = '0;
            end
            S_MUL: begin
                o_alu_b_sel = R2;
                o_alu_op    = OP_MUL;
                o_sel_in    = 1'b1;
                // R0 captures the product only once the multi-cycle ALU has settled.
                if (r_mc == MC_LAST) begin
                    o_ld        = 4'b0001;
                    w_state_nxt = S_SUB;
                end else begin
                    w_mc_nxt = r_mc + CNT_W'(1);
                end
            end
            S_SUB: begin
                o_alu_b_sel = R3;
                o_alu_op    = OP_SUB;
                o_sel_in    = 1'b1;
                o_ld        = 4'b0001;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                o_out_ld    = 1'b1;
                o_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_expr_ctrl.sv
// Directed bench for expr_ctrl: three instances (MUL_CYCLES 1, 3, 4) share stimulus; a small
// datapath model on the MUL_CYCLES=1 instance checks the end-to-end arithmetic.
module tb_expr_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] bus = 16'h0000;

    logic       in_ready [3];
    logic [3:0] ld       [3];
    logic       sel_in   [3];
    logic [1:0] a_sel    [3];
    logic [1:0] b_sel    [3];
    logic [1:0] alu_op   [3];
    logic       out_ld   [3];
    logic       busy     [3];
    logic       done     [3];

    int mcv [3] = '{1, 3, 4};
    int n_checks = 0;
    int n_err = 0;
    logic [15:0] ops [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        expr_ctrl #(
            .MUL_CYCLES((g == 0) ? 1 : ((g == 1) ? 3 : 4)),
            .CNT_W     (4)
        ) u_dut (
            .i_clk      (clk),
            .i_rst_n    (rst_n),
            .i_start    (start),
            .i_in_valid (in_valid),
            .o_in_ready (in_ready[g]),
            .o_ld       (ld[g]),
            .o_sel_in   (sel_in[g]),
            .o_alu_a_sel(a_sel[g]),
            .o_alu_b_sel(b_sel[g]),
            .o_alu_op   (alu_op[g]),
            .o_out_ld   (out_ld[g]),
            .o_busy     (busy[g]),
            .o_done     (done[g])
        );
    end

    // Reference datapath: four registers, shared ALU and output register.
    logic [15:0] dp_r [4];
    logic [15:0] dp_out;
    logic [15:0] dp_a, dp_b, dp_alu;

    always_comb begin
        dp_a = dp_r[a_sel[0]];
        dp_b = dp_r[b_sel[0]];
        case (alu_op[0])
            2'b00:   dp_alu = dp_a + dp_b;
            2'b01:   dp_alu = dp_a - dp_b;
            2'b10:   dp_alu = dp_a * dp_b;
            default: dp_alu = dp_a;
        endcase
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) dp_r[k] <= 16'h0000;
            dp_out <= 16'h0000;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (ld[0][k]) dp_r[k] <= sel_in[0] ? dp_alu : bus;
            end
            if (out_ld[0]) dp_out <= dp_alu;
        end
    end

    task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_checks++;
        if (got_v !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got_v, exp_v);
        end
    endtask

    function automatic logic [14:0] pk(input logic rdy, input logic [3:0] l, input logic s,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] o, input logic ol, input logic bz,
                                       input logic dn);
        return {rdy, l, s, a, b, o, ol, bz, dn};
    endfunction

    function automatic logic [14:0] got(input int i);
        return {in_ready[i], ld[i], sel_in[i], a_sel[i], b_sel[i], alu_op[i],
                out_ld[i], busy[i], done[i]};
    endfunction

    function automatic logic [14:0] v_idle();
        return pk(1'b0, 4'b0000, 1'b0, 2'd0, 2'd0, 2'b11, 1'b0, 1'b0, 1'b0);
    endfunction

    // Expected outputs c cycles after start was sampled, in_valid held high.
    function automatic logic [14:0] exp_plain(input int mc, input int c);
        if (c >= 1 && c <= 4)
            return pk(1'b1, 4'(1 << (c - 1)), 1'b0, 2'd0, 2'd0, 2'b11, 1'b0, 1'b1, 1'b0);
        if (c == 5)
            return pk(1'b0, 4'b0001, 1'b1, 2'd0, 2'd1, 2'b00, 1'b0, 1'b1, 1'b0);
        if (c >= 6 && c <= 5 + mc)
            return pk(1'b0, (c == 5 + mc) ? 4'b0001 : 4'b0000, 1'b1, 2'd0, 2'd2, 2'b10,
                      1'b0, 1'b1, 1'b0);
        if (c == 6 + mc)
            return pk(1'b0, 4'b0001, 1'b1, 2'd0, 2'd3, 2'b01, 1'b0, 1'b1, 1'b0);
        if (c == 7 + mc)
            return pk(1'b0, 4'b0000, 1'b0, 2'd0, 2'd0, 2'b11, 1'b1, 1'b1, 1'b1);
        return v_idle();
    endfunction

    // Same, with in_valid dropped on cycles 2 and 3.
    function automatic logic [14:0] exp_stall(input int mc, input int c);
        if (c <= 1) return exp_plain(mc, c);
        if (c <= 3)
            return pk(1'b1, 4'b0000, 1'b0, 2'd0, 2'd0, 2'b11, 1'b0, 1'b1, 1'b0);
        return exp_plain(mc, c - 2);
    endfunction

    function automatic logic [15:0] bus_for(input int c, input bit stall);
        if (stall) begin
            if (c == 1) return ops[0];
            if (c >= 4 && c <= 6) return ops[c - 3];
        end else if (c >= 1 && c <= 4) begin
            return ops[c - 1];
        end
        return 16'hDEAD;
    endfunction

    // Entered just after a rising edge; cycle 0 is the IDLE cycle in which start is seen.
    task automatic run_seq(input string nm, input int last, input int start_pulse,
                           input bit stall, input int rst_at, input logic [15:0] exp_res);
        for (int c = 0; c <= last; c++) begin
            start    = (c == 0) || (c == start_pulse);
            in_valid = !(stall && (c == 2 || c == 3));
            bus      = bus_for(c, stall);
            #2;
            for (int i = 0; i < 3; i++) begin
                check($sformatf("%s mc%0d c%0d", nm, mcv[i], c), 32'(got(i)),
                      32'(stall ? exp_stall(mcv[i], c) : exp_plain(mcv[i], c)));
            end
            if (c == (stall ? 11 : 9)) check($sformatf("%s result", nm), 32'(dp_out), 32'(exp_res));
            if (c == rst_at) begin
                rst_n = 1'b0;
                #1;
                for (int i = 0; i < 3; i++)
                    check($sformatf("%s async rst mc%0d", nm, mcv[i]), 32'(got(i)), 32'(v_idle()));
                start = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        #2;
        for (int i = 0; i < 3; i++)
            check($sformatf("reset mc%0d", mcv[i]), 32'(got(i)), 32'(v_idle()));
        start    = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #2;
        for (int i = 0; i < 3; i++)
            check($sformatf("start in reset mc%0d", mcv[i]), 32'(got(i)), 32'(v_idle()));
        start    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset during the second MUL cycle of the MUL_CYCLES=3 instance.
        ops = '{16'd1, 16'd2, 16'd3, 16'd4};
        run_seq("rst_mid_mul", 7, -1, 1'b0, 7, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        for (int i = 0; i < 3; i++)
            check($sformatf("idle after rst mc%0d", mcv[i]), 32'(got(i)), 32'(v_idle()));
        @(posedge clk);
        #1;

        ops = '{16'd3, 16'd5, 16'd4, 16'd7};
        run_seq("basic", 12, -1, 1'b0, -1, 16'h0019);

        ops = '{16'd10, 16'd2, 16'd3, 16'd6};
        run_seq("stall", 14, -1, 1'b1, -1, 16'd30);

        // start pulsed during SUB (MUL for the slower instances); in_valid stays high in IDLE.
        ops = '{16'd100, 16'd20, 16'd3, 16'd60};
        in_valid = 1'b1;
        run_seq("busy_start", 13, 7, 1'b0, -1, 16'd300);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/expr_ctrl.md
Name: expr_ctrl

Overview:
- Control FSM for the expression-solver datapath: four 16-bit operand registers R0..R3, one shared ALU and an output register.
- Collects four operands over a valid/ready handshake into R0..R3.
- Sequences the ALU to compute result = ((R0 + R1) * R2) - R3, accumulating into R0, then loads the output register.
- Emits only control signals (load enables, mux selects, ALU opcode, status). Holds no data.

Parameters:
- MUL_CYCLES, 1, number of cycles the ALU needs for MUL (legal range 1..15).
- CNT_W, 4, width of the internal multi-cycle counter (must hold MUL_CYCLES).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request a new evaluation; sampled only in IDLE.
- in_valid  in  1  operand present on the datapath input bus.
- in_ready  out  1  controller accepts an operand this cycle.
- ld  out  4  load enables for R3..R0 (bit k loads Rk).
- sel_in  out  1  register input mux: 0 = external input bus, 1 = ALU result.
- alu_a_sel  out  2  register index driving ALU port A.
- alu_b_sel  out  2  register index driving ALU port B.
- alu_op  out  2  00 ADD, 01 SUB, 10 MUL, 11 PASS A.
- out_ld  out  1  load the output register from ALU (PASS R0).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the result is in the output register path.

Behaviour:
- States: IDLE, LOAD, ADD, MUL, SUB, DONE. Register state, 2-bit operand counter cnt, and multi-cycle counter mc.
- Reset (rst=0, any time, including mid-operation): state=IDLE, cnt=0, mc=0, immediately and asynchronously.
- Default / IDLE outputs: in_ready=0, ld=0, sel_in=0, alu_a_sel=0, alu_b_sel=0, alu_op=PASS, out_ld=0, busy=0, done=0.
- IDLE: start=1 -> LOAD with cnt=0. Otherwise stay.
- LOAD:
  - in_ready=1, sel_in=0.
  - ld[cnt] = in_valid (combinational); all other ld bits 0.
  - On in_valid: cnt increments. If cnt was 3, go to ADD.
  - in_valid=0 stalls indefinitely with no loads.
- ADD: alu_a_sel=0, alu_b_sel=1, alu_op=ADD, sel_in=1, ld=0001. Next state MUL with mc=0.
- MUL: alu_a_sel=0, alu_b_sel=2, alu_op=MUL, sel_in=1.
  - ld=0001 only on the cycle where mc==MUL_CYCLES-1; otherwise ld=0 and mc increments.
  - On that last cycle, go to SUB.
- SUB: alu_a_sel=0, alu_b_sel=3, alu_op=SUB, sel_in=1, ld=0001. Next state DONE.
- DONE: alu_op=PASS, alu_a_sel=0, out_ld=1, done=1. Next state IDLE.
- Latency with in_valid held high: start seen at edge 0, LOAD occupies cycles 1-4, ADD cycle 5, MUL cycles 6..5+MUL_CYCLES, SUB cycle 6+MUL_CYCLES, done in cycle 7+MUL_CYCLES (cycle 8 for the default).
- start while busy is ignored and not queued.
- in_valid outside LOAD is ignored; in_ready=0 there.
- Arithmetic width and overflow are the datapath's concern. The controller makes no data decisions.
- All outputs are combinational decodes of state/cnt/mc/in_valid. No output is registered.

Decomposition:
- Shared package/header holds:
  - ALU opcode constants: OP_ADD, OP_SUB, OP_MUL, OP_PASS.
  - State encodings: S_IDLE..S_DONE.
  - Register index constants: R0..R3.
- No sub-module: single FSM with two counters. A separate datapath top (expr_datapath) instantiates the existing register block four times plus the output register.

Test Plan:
- Reset mid-MUL (MUL_CYCLES=3, rst low in 2nd MUL cycle) -> outputs go to IDLE values immediately; busy=0. The next start runs a full sequence from LOAD cnt=0.
- Basic run, MUL_CYCLES=1, in_valid held 1, start for one cycle -> ld=0001,0010,0100,1000 on cycles 1-4 with sel_in=0; ADD/MUL/SUB on cycles 5/6/7 with ld=0001, sel_in=1, opcodes 00/10/01; done=out_ld=1 on cycle 8 only.
- Stalled handshake: in_valid low on cycles 2-3 of LOAD -> ld=0 and in_ready=1 while stalled; cnt holds; R1 loads on the cycle in_valid returns; total latency grows by 2.
- MUL_CYCLES=4 -> alu_op=MUL for 4 cycles; ld=0001 only on the 4th; done 3 cycles later than the default run.
- start pulsed during SUB and in_valid high in IDLE -> no new LOAD, no ld activity; state returns to IDLE after DONE.
- Integrated with datapath: operands 3, 5, 4, 7 -> output register = ((3+5)*4)-7 = 25 (16'h0019) when done=1.
